receiver: RTL

RECEIVER -- requirements
Module: receiver

---
 rtl/receiver.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/receiver.sv
// rtl/receiver.sv - 8N1 UART receiver with two-flop line synchronizer.
// Optional stop-bit error reporting on o_Rx_Frame_Err when RX_FRAME_ERR_EN is defined.
module receiver #(
    parameter int CLKS_PER_BIT = 2
) (
    input  logic       i_Clock,
    input  logic       i_Reset,
    input  logic       i_Rx_Serial,
    output logic       o_Rx_DV,
    output logic [7:0] o_Rx_Byte,
    output logic       o_Rx_Active
`ifdef RX_FRAME_ERR_EN
    ,
    output logic       o_Rx_Frame_Err
`endif
);

    localparam logic [7:0] LAST = 8'(CLKS_PER_BIT - 1);
    localparam logic [7:0] HALF = 8'((CLKS_PER_BIT - 1) / 2);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START   = 3'd1,
        DATA    = 3'd2,
        STOP    = 3'd3,
        CLEANUP = 3'd4
    } state_t;

    state_t     state_q, state_d;
    logic       sync1_q, sync2_q;
    logic [7:0] count_q, count_d;
    logic [2:0] bit_index_q, bit_index_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] rx_byte_q, rx_byte_d;
    logic       rx_dv_q, rx_dv_d;
    logic       rx_active_q, rx_active_d;
`ifdef RX_FRAME_ERR_EN
    logic       frame_err_q, frame_err_d;
`endif

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        bit_index_d = bit_index_q;
        shift_d     = shift_q;
        rx_byte_d   = rx_byte_q;
        rx_dv_d     = 1'b0;
        rx_active_d = rx_active_q;
`ifdef RX_FRAME_ERR_EN
        frame_err_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                count_d     = 8'd0;
                bit_index_d = 3'd0;
                if (!sync2_q) begin
                    state_d     = START;
                    rx_active_d = 1'b1;
                end
            end
            START: begin
                // Re-check the line mid start bit so a short glitch is rejected.
                if (count_q == HALF) begin
                    count_d = 8'd0;
                    if (!sync2_q) begin
                        state_d = DATA;
                    end else begin
                        state_d     = IDLE;
                        rx_active_d = 1'b0;
                    end
                end else begin
                    count_d = count_q + 8'd1;
                end
            end
            DATA: begin
                if (count_q == LAST) begin
                    count_d              = 8'd0;
                    shift_d[bit_index_q] = sync2_q;
                    if (bit_index_q == 3'd7) begin
                        bit_index_d = 3'd0;
                        state_d     = STOP;
                    end else begin
                        bit_index_d = bit_index_q + 3'd1;
                    end
                end else begin
                    count_d = count_q + 8'd1;
                end
            end
            STOP: begin
                if (count_q == LAST) begin
                    count_d   = 8'd0;
                    rx_byte_d = shift_q;
                    state_d   = CLEANUP;
`ifdef RX_FRAME_ERR_EN
                    if (sync2_q) begin
                        rx_dv_d = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
`else
                    rx_dv_d = 1'b1;
`endif
                end else begin
                    count_d = count_q + 8'd1;
                end
            end
            CLEANUP: begin
                rx_active_d = 1'b0;
                state_d     = IDLE;
            end
            default: begin
                state_d     = IDLE;
                count_d     = 8'd0;
                bit_index_d = 3'd0;
                rx_active_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            state_q     <= IDLE;
            count_q     <= 8'd0;
            bit_index_q <= 3'd0;
            shift_q     <= 8'd0;
            rx_byte_q   <= 8'd0;
            rx_dv_q     <= 1'b0;
            rx_active_q <= 1'b0;
`ifdef RX_FRAME_ERR_EN
            frame_err_q <= 1'b0;
`endif
        end else begin
            sync1_q     <= i_Rx_Serial;
            sync2_q     <= sync1_q;
            state_q     <= state_d;
            count_q     <= count_d;
            bit_index_q <= bit_index_d;
            shift_q     <= shift_d;
            rx_byte_q   <= rx_byte_d;
            rx_dv_q     <= rx_dv_d;
            rx_active_q <= rx_active_d;
`ifdef RX_FRAME_ERR_EN
            frame_err_q <= frame_err_d;
`endif
        end
    end

    assign o_Rx_DV     = rx_dv_q;
    assign o_Rx_Byte   = rx_byte_q;
    assign o_Rx_Active = rx_active_q;
`ifdef RX_FRAME_ERR_EN
    assign o_Rx_Frame_Err = frame_err_q;
`endif

endmodule
